// File: rtl/lfsr_stream_checker_if.sv
// lfsr_stream_checker_if
//   Bundles the checker's data and status signals so the checker and the
//   block that feeds it share one connection point.
//   Stimulus side (master drives, slave receives):
//     seed[7:0]      initial LFSR value, loaded while reset is asserted
//     enable_in      step the local LFSR one position
//     ser_in         received serial data bit
//     ser_valid      ser_in is valid this cycle
//     clear          synchronous clear of err_cnt and abort
//   Status side (slave drives, master receives):
//     rx_byte[7:0]   last assembled byte, LSB = first bit received
//     byte_done      one-cycle pulse when rx_byte / byte_ok update
//     byte_ok        last completed byte matched on all 8 bits
//     bit_err        one-cycle pulse on an accepted mismatching bit
//     err_cnt        saturating mismatch count (ERR_W bits)
//     abort          sticky: a frame was cut short by enable_in
interface lfsr_stream_checker_if #(
  parameter int unsigned ERR_W = 8
);
  logic [7:0]       seed;
  logic             enable_in;
  logic             ser_in;
  logic             ser_valid;
  logic             clear;
  logic [7:0]       rx_byte;
  logic             byte_done;
  logic             byte_ok;
  logic             bit_err;
  logic [ERR_W-1:0] err_cnt;
  logic             abort;

  modport master (
    output seed, enable_in, ser_in, ser_valid, clear,
    input  rx_byte, byte_done, byte_ok, bit_err, err_cnt, abort
  );

  modport slave (
    input  seed, enable_in, ser_in, ser_valid, clear,
    output rx_byte, byte_done, byte_ok, bit_err, err_cnt, abort
  );
endinterface

// File: rtl/lfsr_stream_checker.sv
// lfsr_stream_checker
//   Receive-side checker for the 8-bit LFSR pattern generator. Runs a local
//   copy of the generator's LFSR (same seed, same enable_in stepping), compares
//   each received serial bit (LSB first) with the expected bit, assembles bytes
//   and reports per-bit errors, per-byte pass/fail and a saturating error count.
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous active-low reset (LFSR reloads seed)
//     bus   lfsr_stream_checker_if.slave (stimulus in, status out)
module lfsr_stream_checker #(
  parameter logic [7:0]  TAPS  = 8'b10101010,
  parameter int unsigned ERR_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  lfsr_stream_checker_if.slave  bus
);

  typedef enum logic {IDLE, RECV} state_e;

  state_e           state_q,     state_d;
  logic [2:0]       bit_cnt_q,   bit_cnt_d;
  logic [7:0]       lfsr_q,      lfsr_d;
  logic [7:0]       shreg_q,     shreg_d;
  logic             frame_err_q, frame_err_d;
  logic [7:0]       rx_byte_q,   rx_byte_d;
  logic             byte_done_q, byte_done_d;
  logic             byte_ok_q,   byte_ok_d;
  logic             bit_err_q,   bit_err_d;
  logic [ERR_W-1:0] err_cnt_q,   err_cnt_d;
  logic             abort_q,     abort_d;

  logic             fb;
  logic             mismatch;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      lfsr_q      <= bus.seed;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
      rx_byte_q   <= '0;
      byte_done_q <= 1'b0;
      byte_ok_q   <= 1'b0;
      bit_err_q   <= 1'b0;
      err_cnt_q   <= '0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      lfsr_q      <= lfsr_d;
      shreg_q     <= shreg_d;
      frame_err_q <= frame_err_d;
      rx_byte_q   <= rx_byte_d;
      byte_done_q <= byte_done_d;
      byte_ok_q   <= byte_ok_d;
      bit_err_q   <= bit_err_d;
      err_cnt_q   <= err_cnt_d;
      abort_q     <= abort_d;
    end
  end

  // Feedback includes the all-zero escape term so a zero seed still runs.
  assign fb = (~|lfsr_q[6:0]) ^ lfsr_q[7];

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    lfsr_d      = lfsr_q;
    shreg_d     = shreg_q;
    frame_err_d = frame_err_q;
    rx_byte_d   = rx_byte_q;
    byte_done_d = 1'b0;
    byte_ok_d   = byte_ok_q;
    bit_err_d   = 1'b0;
    err_cnt_d   = err_cnt_q;
    abort_d     = abort_q;
    mismatch    = 1'b0;

    if (bus.clear) begin
      err_cnt_d = '0;
      abort_d   = 1'b0;
    end

    if (bus.enable_in) begin
      lfsr_d[0] = fb;
      for (int unsigned i = 1; i < 8; i++) begin
        lfsr_d[i] = lfsr_q[i-1] ^ (TAPS[i] & fb);
      end
      // Any partially received frame is dropped; ser_valid is ignored.
      if (state_q == RECV) begin
        state_d   = IDLE;
        bit_cnt_d = '0;
        abort_d   = 1'b1;
      end
    end else if (bus.ser_valid) begin
      mismatch          = bus.ser_in ^ lfsr_q[0];
      // Mirrors the generator's output shift: MSB held, rest move down.
      lfsr_d            = {lfsr_q[7], lfsr_q[7:1]};
      shreg_d[bit_cnt_q] = bus.ser_in;
      bit_err_d         = mismatch;
      frame_err_d       = (state_q == IDLE) ? mismatch : (frame_err_q | mismatch);
      if (mismatch) begin
        // A mismatch coinciding with clear leaves a count of one.
        if (bus.clear)             err_cnt_d = ERR_W'(1);
        else if (err_cnt_q != '1)  err_cnt_d = err_cnt_q + ERR_W'(1);
      end
      bit_cnt_d = bit_cnt_q + 3'd1;
      state_d   = RECV;
      if (bit_cnt_q == 3'd7) begin
        state_d     = IDLE;
        byte_done_d = 1'b1;
        rx_byte_d   = shreg_d;
        byte_ok_d   = ~frame_err_d;
      end
    end
  end

  assign bus.rx_byte   = rx_byte_q;
  assign bus.byte_done = byte_done_q;
  assign bus.byte_ok   = byte_ok_q;
  assign bus.bit_err   = bit_err_q;
  assign bus.err_cnt   = err_cnt_q;
  assign bus.abort     = abort_q;

endmodule

// File: tb/tb_lfsr_stream_checker.sv
module tb_lfsr_stream_checker;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lfsr_stream_checker_if #(.ERR_W(8)) bus8();
  lfsr_stream_checker_if #(.ERR_W(3)) bus3();

  lfsr_stream_checker #(.TAPS(8'b10101010), .ERR_W(8)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  lfsr_stream_checker #(.TAPS(8'b10101010), .ERR_W(3)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  int checks = 0;
  int errors = 0;

  // Pulse monitors, sampled 1 time unit after each rising edge.
  int         done8, ok8, berr8, done3, ok3, berr3;
  logic [7:0] last_rx8, last_rx3;

  always @(posedge clk) begin
    #1;
    if (bus8.byte_done === 1'b1) begin
      done8++; last_rx8 = bus8.rx_byte;
      if (bus8.byte_ok === 1'b1) ok8++;
    end
    if (bus8.bit_err === 1'b1) berr8++;
    if (bus3.byte_done === 1'b1) begin
      done3++; last_rx3 = bus3.rx_byte;
      if (bus3.byte_ok === 1'b1) ok3++;
    end
    if (bus3.bit_err === 1'b1) berr3++;
  end

  task automatic clr_mon();
    done8 = 0; ok8 = 0; berr8 = 0; last_rx8 = '0;
    done3 = 0; ok3 = 0; berr3 = 0; last_rx3 = '0;
  endtask

  task automatic cyc8(input logic en, input logic sv, input logic si, input logic clr);
    bus8.enable_in = en; bus8.ser_valid = sv; bus8.ser_in = si; bus8.clear = clr;
    @(negedge clk);
    bus8.enable_in = 1'b0; bus8.ser_valid = 1'b0; bus8.ser_in = 1'b0; bus8.clear = 1'b0;
  endtask

  task automatic cyc3(input logic en, input logic sv, input logic si, input logic clr);
    bus3.enable_in = en; bus3.ser_valid = sv; bus3.ser_in = si; bus3.clear = clr;
    @(negedge clk);
    bus3.enable_in = 1'b0; bus3.ser_valid = 1'b0; bus3.ser_in = 1'b0; bus3.clear = 1'b0;
  endtask

  task automatic send8(input logic [7:0] b);
    for (int i = 0; i < 8; i++) cyc8(1'b0, 1'b1, b[i], 1'b0);
    cyc8(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send3(input logic [7:0] b);
    for (int i = 0; i < 8; i++) cyc3(1'b0, 1'b1, b[i], 1'b0);
    cyc3(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input logic [7:0] s);
    rst = 1'b0;
    bus8.seed = s; bus3.seed = s;
    bus8.enable_in = 1'b0; bus8.ser_valid = 1'b0; bus8.ser_in = 1'b0; bus8.clear = 1'b0;
    bus3.enable_in = 1'b0; bus3.ser_valid = 1'b0; bus3.ser_in = 1'b0; bus3.clear = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    clr_mon();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus8.seed = 8'h00; bus3.seed = 8'h00;
    bus8.enable_in = 1'b0; bus8.ser_valid = 1'b0; bus8.ser_in = 1'b0; bus8.clear = 1'b0;
    bus3.enable_in = 1'b0; bus3.ser_valid = 1'b0; bus3.ser_in = 1'b0; bus3.clear = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus8.rx_byte, bus8.byte_done, bus8.byte_ok, bus8.bit_err, bus8.err_cnt, bus8.abort} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outs8 got rx=%h done=%b ok=%b berr=%b cnt=%h abort=%b exp all 0",
               bus8.rx_byte, bus8.byte_done, bus8.byte_ok, bus8.bit_err, bus8.err_cnt, bus8.abort);
    end
    checks++;
    if ({bus3.rx_byte, bus3.byte_done, bus3.byte_ok, bus3.bit_err, bus3.err_cnt, bus3.abort} !== 16'd0) begin
      errors++;
      $display("FAIL reset_outs3 got rx=%h done=%b ok=%b berr=%b cnt=%h abort=%b exp all 0",
               bus3.rx_byte, bus3.byte_done, bus3.byte_ok, bus3.bit_err, bus3.err_cnt, bus3.abort);
    end
  endtask

  task automatic test_good_frames();
    do_reset(8'h00);
    cyc8(1'b1, 1'b0, 1'b0, 1'b0);   // 00 -> AB
    send8(8'hAB);
    checks++; if (done8 !== 1) begin errors++; $display("FAIL good_done got %0d exp 1", done8); end
    checks++; if (last_rx8 !== 8'hAB) begin errors++; $display("FAIL good_rx got %h exp ab", last_rx8); end
    checks++; if (ok8 !== 1) begin errors++; $display("FAIL good_ok got %0d exp 1", ok8); end
    checks++; if (berr8 !== 0) begin errors++; $display("FAIL good_biterr got %0d exp 0", berr8); end
    checks++; if (bus8.err_cnt !== 8'd0) begin errors++; $display("FAIL good_errcnt got %0d exp 0", bus8.err_cnt); end
    cyc8(1'b1, 1'b0, 1'b0, 1'b0);   // FF -> 55
    send8(8'h55);
    checks++; if (done8 !== 2) begin errors++; $display("FAIL next_done got %0d exp 2", done8); end
    checks++; if (last_rx8 !== 8'h55) begin errors++; $display("FAIL next_rx got %h exp 55", last_rx8); end
    checks++; if (ok8 !== 2 || bus8.byte_ok !== 1'b1) begin errors++; $display("FAIL next_ok got %0d/%b exp 2/1", ok8, bus8.byte_ok); end
    checks++; if (berr8 !== 0) begin errors++; $display("FAIL next_biterr got %0d exp 0", berr8); end
  endtask

  task automatic test_bad_bit();
    do_reset(8'h00);
    cyc8(1'b1, 1'b0, 1'b0, 1'b0);
    send8(8'hAF);                    // bit 2 inverted
    checks++; if (done8 !== 1) begin errors++; $display("FAIL bad_done got %0d exp 1", done8); end
    checks++; if (last_rx8 !== 8'hAF) begin errors++; $display("FAIL bad_rx got %h exp af", last_rx8); end
    checks++; if (berr8 !== 1) begin errors++; $display("FAIL bad_biterr got %0d exp 1", berr8); end
    checks++; if (bus8.err_cnt !== 8'd1) begin errors++; $display("FAIL bad_errcnt got %0d exp 1", bus8.err_cnt); end
    checks++; if (ok8 !== 0 || bus8.byte_ok !== 1'b0) begin errors++; $display("FAIL bad_ok got %0d/%b exp 0/0", ok8, bus8.byte_ok); end
  endtask

  task automatic test_abort();
    do_reset(8'h00);
    cyc8(1'b1, 1'b0, 1'b0, 1'b0);   // AB
    cyc8(1'b0, 1'b1, 1'b1, 1'b0);
    cyc8(1'b0, 1'b1, 1'b1, 1'b0);
    cyc8(1'b0, 1'b1, 1'b0, 1'b0);   // LFSR now F5
    cyc8(1'b1, 1'b1, 1'b1, 1'b0);   // step F5 -> 41, bit ignored
    checks++; if (bus8.abort !== 1'b1) begin errors++; $display("FAIL abort_set got %b exp 1", bus8.abort); end
    for (int i = 0; i < 5; i++) cyc8(1'b0, 1'b1, (i == 0), 1'b0);  // 1,0,0,0,0
    checks++; if (done8 !== 0) begin errors++; $display("FAIL abort_nodone got %0d exp 0", done8); end
    cyc8(1'b0, 1'b1, 1'b0, 1'b0);
    cyc8(1'b0, 1'b1, 1'b1, 1'b0);
    cyc8(1'b0, 1'b1, 1'b0, 1'b0);
    cyc8(1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (done8 !== 1 || last_rx8 !== 8'h41) begin errors++; $display("FAIL abort_refr got done=%0d rx=%h exp 1/41", done8, last_rx8); end
    checks++; if (ok8 !== 1 || berr8 !== 0) begin errors++; $display("FAIL abort_ok got ok=%0d berr=%0d exp 1/0", ok8, berr8); end
    checks++; if (bus8.abort !== 1'b1) begin errors++; $display("FAIL abort_sticky got %b exp 1", bus8.abort); end
    cyc8(1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (bus8.abort !== 1'b0) begin errors++; $display("FAIL abort_clear got %b exp 0", bus8.abort); end
  endtask

  task automatic test_saturate();
    do_reset(8'h00);
    cyc3(1'b1, 1'b0, 1'b0, 1'b0);   // AB
    send3(8'h54);                    // ~AB
    checks++; if (bus3.err_cnt !== 3'd7) begin errors++; $display("FAIL sat_first got %0d exp 7", bus3.err_cnt); end
    send3(8'h00);                    // ~FF
    checks++; if (bus3.err_cnt !== 3'd7) begin errors++; $display("FAIL sat_hold got %0d exp 7", bus3.err_cnt); end
    checks++; if (done3 !== 2 || ok3 !== 0) begin errors++; $display("FAIL sat_bytes got done=%0d ok=%0d exp 2/0", done3, ok3); end
    checks++; if (berr3 !== 16) begin errors++; $display("FAIL sat_biterr got %0d exp 16", berr3); end
    cyc3(1'b0, 1'b1, 1'b0, 1'b1);   // clear with a mismatch (expected 1)
    checks++; if (bus3.err_cnt !== 3'd1) begin errors++; $display("FAIL sat_clrmis got %0d exp 1", bus3.err_cnt); end
    checks++; if (bus3.rx_byte !== 8'h00) begin errors++; $display("FAIL sat_rxhold got %h exp 00", bus3.rx_byte); end
  endtask

  task automatic test_reset_mid_frame();
    do_reset(8'h00);
    cyc8(1'b1, 1'b0, 1'b0, 1'b0);   // AB
    cyc8(1'b0, 1'b1, 1'b1, 1'b0);
    cyc8(1'b0, 1'b1, 1'b1, 1'b0);
    cyc8(1'b0, 1'b1, 1'b1, 1'b0);   // mismatch
    cyc8(1'b0, 1'b1, 1'b1, 1'b0);
    cyc8(1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (bus8.err_cnt !== 8'd1) begin errors++; $display("FAIL mid_pre got %0d exp 1", bus8.err_cnt); end
    #2;
    bus8.seed = 8'h3C;
    rst = 1'b0;
    #1;
    checks++;
    if ({bus8.rx_byte, bus8.byte_done, bus8.byte_ok, bus8.bit_err, bus8.err_cnt, bus8.abort} !== 21'd0) begin
      errors++;
      $display("FAIL mid_async got rx=%h done=%b ok=%b berr=%b cnt=%h abort=%b exp all 0",
               bus8.rx_byte, bus8.byte_done, bus8.byte_ok, bus8.bit_err, bus8.err_cnt, bus8.abort);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    clr_mon();
    send8(8'h3C);
    checks++; if (done8 !== 1 || last_rx8 !== 8'h3C) begin errors++; $display("FAIL mid_frame got done=%0d rx=%h exp 1/3c", done8, last_rx8); end
    checks++; if (ok8 !== 1 || berr8 !== 0) begin errors++; $display("FAIL mid_ok got ok=%0d berr=%0d exp 1/0", ok8, berr8); end
  endtask

  initial begin
    test_reset();
    test_good_frames();
    test_bad_bit();
    test_abort();
    test_saturate();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_stream_checker.md
Name: lfsr_stream_checker

Overview:
- Receive-side companion to the team's 8-bit LFSR pattern generator.
- Runs a local copy of the same LFSR, started from the same seed and stepped on the same enable_in strobe.
- Takes the generator's serial output, one bit per ser_valid strobe, least-significant bit first, and compares each bit against the expected bit.
- Reports per-bit mismatches, per-byte pass/fail and a saturating error count. Used as a BIST / link checker at the far end of the serial pattern path.

Parameters:
- TAPS, 8'b10101010, feedback tap mask; must equal the generator's tap mask.
- ERR_W, 8, width of the saturating mismatch counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- seed  input  8  initial LFSR value, loaded while rst is low.
- enable_in  input  1  step the local LFSR one position (mirrors the generator's enable_in).
- ser_in  input  1  received serial data bit.
- ser_valid  input  1  ser_in is valid this cycle (one bit per asserted cycle).
- clear  input  1  synchronous clear of err_cnt and sticky flags.
- rx_byte  output  8  last assembled received byte, LSB = first bit received.
- byte_done  output  1  one-cycle pulse: rx_byte / byte_ok updated.
- byte_ok  output  1  last completed byte matched expected on all 8 bits.
- bit_err  output  1  one-cycle pulse: accepted bit mismatched.
- err_cnt  output  ERR_W  saturating count of mismatched bits.
- abort  output  1  sticky: a frame was cut short by enable_in.

Behaviour:
- Reset (rst low, async):
  - local LFSR = seed.
  - Shift/assembly register, bit_cnt, rx_byte, byte_done, byte_ok, bit_err, err_cnt and abort = 0.
- Priority each cycle: enable_in > ser_valid. clear acts in parallel (see below).
- Step rule when enable_in = 1, with fb = (~|L[6:0]) ^ L[7]:
  - L[0] <= fb.
  - For i = 7..1: L[i] <= L[i-1] ^ (TAPS[i] & fb).
- Frame interruption by enable_in:
  - If bit_cnt != 0, the partial frame is discarded: bit_cnt <= 0, abort <= 1, no byte_done.
  - ser_valid in the same cycle is ignored.
- Bit accept (ser_valid = 1, enable_in = 0):
  - Expected bit = L[0].
  - L shifts to mirror the generator's output shift: L[6:0] <= L[7:1], L[7] held.
  - ser_in is written into assembly position bit_cnt.
  - bit_err registered high for exactly one cycle if ser_in != expected.
  - err_cnt increments on each mismatch and saturates at all-ones (no wrap).
- Frame FSM, tracked by 3-bit bit_cnt:
  - IDLE (bit_cnt = 0) -> RECV on the first accepted bit.
  - RECV: each accepted bit increments bit_cnt.
  - The 8th accepted bit returns to IDLE (bit_cnt wraps 7 -> 0).
- Byte completion, in the cycle after the edge that accepts the 8th bit:
  - byte_done = 1 for exactly that one cycle.
  - rx_byte = assembled byte.
  - byte_ok = 1 iff none of the 8 bits in the frame mismatched. A per-frame error flag is cleared at frame start.
- Hold rules:
  - rx_byte and byte_ok hold until the next completed byte.
  - The local LFSR holds when neither strobe is active.
- Clear (clear = 1, synchronous):
  - err_cnt <= 0 and abort <= 0.
  - A mismatch in the same cycle wins: err_cnt <= 1.
  - clear does not affect the LFSR, the frame in progress or rx_byte.
- After a full 8-bit frame the local LFSR equals {8{L7_at_frame_start}}, exactly matching the generator's post-shift state.
- Latency: bit_err and byte_done become visible 1 clock after the accepting edge.
- Reset mid-frame: everything returns to reset values, and the LFSR reloads seed.

Test Plan:
- Seed 8'h00, TAPS default; release reset; one enable_in cycle -> local LFSR = 8'hAB. Stream bits 1,1,0,1,0,1,0,1 with ser_valid -> one byte_done pulse, rx_byte = 8'hAB, byte_ok = 1, bit_err never high, err_cnt = 0.
- Same setup, but bit 2 inverted -> rx_byte = 8'hAF, exactly one bit_err pulse, err_cnt = 1, byte_ok = 0.
- Continue after the good 8'hAB frame: one enable_in -> expected 8'h55. Stream 1,0,1,0,1,0,1,0 -> byte_ok = 1, rx_byte = 8'h55.
- Send 3 bits, then enable_in with ser_valid high in the same cycle -> no byte_done, abort = 1, bit_cnt = 0, ser bit ignored. Then clear -> abort = 0.
- ERR_W = 3: stream 16 inverted bits -> err_cnt saturates at 7, two byte_done pulses, both byte_ok = 0. Then clear plus a mismatch in the same cycle -> err_cnt = 1.
- Assert rst low mid-frame (after 5 bits) with seed 8'h3C -> all outputs 0 asynchronously, LFSR = 8'h3C. The next 8 accepted bits form a fresh frame.
